// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared state encoding and defaults for the Wishbone command master.
package wb_cmd_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_WD_DEF = 8;
  localparam int RSP_ERR_DATA = 0;
endpackage

// File: rtl/wbm_timeout_ctr.sv
// wbm_timeout_ctr: counts enabled cycles since the last clear and flags when TIMEOUT is reached.
module wbm_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int TO_WD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_WD-1:0] count;
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  end
  assign expired = count == TO_WD'(TIMEOUT);
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns one valid/ready command into a single Wishbone classic cycle and
// returns read data or an error (slave error or timeout) on a valid/ready response stream.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int WB_WIDTH = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_WD = TO_WD_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [WB_WIDTH-1:0]   cmd_adr_i,
  input  logic [WB_WIDTH-1:0]   cmd_dat_i,
  input  logic [WB_WIDTH/8-1:0] cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WB_WIDTH-1:0]   rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [WB_WIDTH-1:0]   wbm_adr_o,
  output logic [WB_WIDTH-1:0]   wbm_dat_o,
  output logic [WB_WIDTH/8-1:0] wbm_sel_o,
  input  logic [WB_WIDTH-1:0]   wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);
  state_t state, state_n;
  logic accept, expired, term, count_en;
  assign cmd_ready_o = state == IDLE;
  // Counting starts on the accept edge so the count equals the cycles stb has been high.
  assign count_en = accept || state == BUS;
  wbm_timeout_ctr #(.TIMEOUT(TIMEOUT), .TO_WD(TO_WD)) u_to (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clear(!count_en),
    .enable(count_en),
    .expired(expired)
  );
  always_comb begin
    accept = cmd_valid_i && cmd_ready_o;
    term = wbm_ack_i || wbm_err_i || expired;
    state_n = state == IDLE ? (accept ? BUS : IDLE) :
              state == BUS  ? (term ? RESP : BUS) :
                              (rsp_ready_i ? IDLE : RESP);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        wbm_sel_o <= cmd_sel_i;
      end
      // err beats ack, and any real termination beats the timeout abort.
      if (state == BUS && term) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= wbm_err_i || !wbm_ack_i;
        rsp_dat_o   <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : WB_WIDTH'(RSP_ERR_DATA);
      end
      if (state == RESP && rsp_ready_i) rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed checks of wb_cmd_master with a hand-driven Wishbone slave.
module tb_wb_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0] cmd_sel = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic cyc, stb, we;
  logic [31:0] adr, dat_o, dat_i = '0;
  logic [3:0] sel;
  logic ack = 1'b0, err = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] b2b_adr [3];
  logic [31:0] b2b_dat [3];
  logic b2b_we [3];

  always #5 clk = ~clk;

  wb_cmd_master #(.WB_WIDTH(32), .TIMEOUT(4), .TO_WD(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_sel_o(sel), .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_cyc", 32'({cyc, stb, we}), 0);
    chk("rst_bus", adr | dat_o | 32'(sel), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}) | rsp_dat, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 1);

    // write, zero-wait slave
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hA5A5_1234; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    chk("wr_cycstbwe", 32'({cyc, stb, we}), 32'h7);
    chk("wr_adr", adr, 32'h3000_0004);
    chk("wr_dat", dat_o, 32'hA5A5_1234);
    chk("wr_sel", 32'(sel), 32'hF);
    chk("wr_ready_low", 32'(cmd_ready), 0);
    ack = 1'b1; dat_i = 32'h5555_AAAA; rsp_ready = 1'b1;
    step();
    ack = 1'b0;
    chk("wr_cyc_drop", 32'({cyc, stb}), 0);
    chk("wr_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_rsp_dat", rsp_dat, 0);
    step();
    chk("wr_done_valid", 32'(rsp_valid), 0);
    chk("wr_done_ready", 32'(cmd_ready), 1);
    rsp_ready = 1'b0;

    // read, 3 wait states; also coincides with timeout expiry, so ack must win
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_dat = 32'h0; cmd_sel = 4'hF;
    step();
    chk("rd_stb1", 32'({cyc, stb, we}), 32'h6);
    chk("rd_adr1", adr, 32'h3000_0010);
    cmd_adr = 32'h7777_7777; cmd_we = 1'b1;
    dat_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_stb_wait", 32'({cyc, stb, we}), 32'h6);
      chk("rd_adr_wait", adr, 32'h3000_0010);
      chk("rd_ready_wait", 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rd_cyc_drop", 32'({cyc, stb}), 0);
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    chk("rd_ready_resp", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_done", 32'({rsp_valid, cmd_ready}), 32'h1);

    // ack+err together, then backpressure
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020;
    step();
    cmd_valid = 1'b0;
    ack = 1'b1; err = 1'b1; dat_i = 32'h1234_5678;
    step();
    ack = 1'b0; err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("err_valid", 32'(rsp_valid), 1);
      chk("err_err", 32'(rsp_err), 1);
      chk("err_dat", rsp_dat, 0);
      chk("err_ready", 32'(cmd_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("err_done", 32'({rsp_valid, cmd_ready}), 32'h1);

    // timeout (TIMEOUT=4), then a late ack two cycles after the abort
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4000_0000;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_stb", 32'({cyc, stb}), 32'h3);
      step();
    end
    chk("to_cyc_drop", 32'({cyc, stb}), 0);
    chk("to_rsp", 32'({rsp_valid, rsp_err}), 32'h3);
    chk("to_dat", rsp_dat, 0);
    step();
    ack = 1'b1; dat_i = 32'hFFFF_0000;
    step();
    ack = 1'b0;
    chk("late_ack_rsp", 32'({rsp_valid, rsp_err}), 32'h3);
    chk("late_ack_dat", rsp_dat, 0);
    chk("late_ack_bus", 32'({cyc, stb, cmd_ready}), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_done", 32'({rsp_valid, cmd_ready}), 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("stray_ack_idle", 32'({rsp_valid, cyc, cmd_ready}), 32'h1);

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h5000_0000; cmd_dat = 32'h0101_0101;
    step();
    cmd_valid = 1'b0;
    chk("mid_stb", 32'({cyc, stb}), 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_bus", 32'({cyc, stb, we}), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("mid_no_rsp", 32'({rsp_valid, cyc}), 0);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000;
    step();
    cmd_valid = 1'b0;
    chk("post_rst_adr", adr, 32'h3000_0000);
    chk("post_rst_stb", 32'({cyc, stb, we}), 32'h6);
    ack = 1'b1; dat_i = 32'h0BAD_BEEF; rsp_ready = 1'b1;
    step();
    ack = 1'b0;
    chk("post_rst_rsp", rsp_dat, 32'h0BAD_BEEF);
    chk("post_rst_valid", 32'({rsp_valid, rsp_err}), 32'h2);
    step();
    chk("post_rst_idle", 32'(cmd_ready), 1);

    // back-to-back read/write/read, rsp_ready held high, one command every 3 cycles
    b2b_adr[0] = 32'h3000_0100; b2b_we[0] = 1'b0; b2b_dat[0] = 32'h1111_1111;
    b2b_adr[1] = 32'h3000_0104; b2b_we[1] = 1'b1; b2b_dat[1] = 32'hDEAD_BEEF;
    b2b_adr[2] = 32'h3000_0108; b2b_we[2] = 1'b0; b2b_dat[2] = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_we = b2b_we[k]; cmd_adr = b2b_adr[k]; cmd_dat = b2b_dat[k]; cmd_sel = 4'h3;
      step();
      cmd_valid = 1'b0;
      chk("b2b_stb", 32'({cyc, stb, we}), 32'({2'b11, b2b_we[k]}));
      chk("b2b_adr", adr, b2b_adr[k]);
      chk("b2b_sel", 32'(sel), 32'h3);
      ack = 1'b1; dat_i = b2b_dat[k] ^ 32'hFFFF_0000;
      step();
      ack = 1'b0;
      chk("b2b_rsp_valid", 32'({rsp_valid, rsp_err}), 32'h2);
      chk("b2b_rsp_dat", rsp_dat, b2b_we[k] ? 32'h0 : (b2b_dat[k] ^ 32'hFFFF_0000));
      step();
      chk("b2b_ready", 32'({cmd_ready, rsp_valid}), 32'h2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
